// File: rtl/game_pkg.sv
// Shared types for the match manager slice.
//   mm_state_e : match sequencer states
//   side_e     : which side is to move
//   SCORE_W    : width of score and game counters
package game_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PRINT,
        ST_MOVE,
        ST_JUDGE,
        ST_GAME_END,
        ST_MATCH_END
    } mm_state_e;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

endpackage

// File: rtl/match_manager_if.sv
// Handshake bundle between the match manager and its four sub-blocks
// (print, make_turn, recv, make_judge).
//   master : the manager (drives req pulses, receives ready/results/boards)
//   slave  : the sub-block side
// CELLS is the board size in bits (ROWS*COLS).
interface match_manager_if #(
    parameter int CELLS = 9
);
    logic             print_board_wr;
    logic             make_turn_req;
    logic             recv_req;
    logic             make_judge_req;
    logic             print_board_ready;
    logic             make_turn_ready;
    logic             recv_ready;
    logic             make_judge_ready;
    logic             recv_error;
    logic             end_of_game;
    logic             win_a;
    logic             win_b;
    logic [CELLS-1:0] make_turn_board_a;
    logic [CELLS-1:0] make_turn_board_b;
    logic [CELLS-1:0] recv_board_a;
    logic [CELLS-1:0] recv_board_b;

    modport master (
        output print_board_wr, make_turn_req, recv_req, make_judge_req,
        input  print_board_ready, make_turn_ready, recv_ready, make_judge_ready,
        input  recv_error, end_of_game, win_a, win_b,
        input  make_turn_board_a, make_turn_board_b, recv_board_a, recv_board_b
    );

    modport slave (
        input  print_board_wr, make_turn_req, recv_req, make_judge_req,
        output print_board_ready, make_turn_ready, recv_ready, make_judge_ready,
        output recv_error, end_of_game, win_a, win_b,
        output make_turn_board_a, make_turn_board_b, recv_board_a, recv_board_b
    );

endinterface

// File: rtl/req_ready_tracker.sv
// One req/ready handshake channel.
//   clk, reset : clock, asynchronous active-low reset
//   start      : the sequencer wants this sub-block run
//   ready      : sub-block idle
//   cancel     : drop an outstanding request without completion
//   req        : one-cycle request pulse (only while ready=1)
//   done       : completion, first ready=1 cycle after the pulse
module req_ready_tracker (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ready,
    input  logic cancel,
    output logic req,
    output logic done
);

    logic busy;

    // busy suppresses further pulses until the sub-block reports idle again,
    // which also guarantees completion is at least one cycle after req
    assign req  = start & ready & ~busy;
    assign done = busy & ready;

    // Outstanding-request flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
        end else if (req) begin
            busy <= 1'b1;
        end else if (done || cancel) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: rtl/match_manager.sv
// Best-of-NUM_GAMES tic-tac-toe match sequencer.
//   clk, reset        : clock, asynchronous active-low reset
//   kick_game         : level, starts a match from IDLE
//   my_target_a       : 1 = local player is side A
//   bus (master)      : req/ready handshakes, judge results, candidate boards
//   board_a/board_b   : current board
//   score_a/score_b   : games won
//   game_no           : current game index
//   match_active, match_done, abort : match status
// Optional build macro MATCH_MANAGER_TIMEOUT_EN adds a recv wait timeout of
// TIMEOUT_CYC cycles that is handled like a recv_error.
module match_manager
    import game_pkg::*;
#(
    parameter int ROWS      = 3,
    parameter int COLS      = 3,
    parameter int NUM_GAMES = 3,
    parameter int MAX_RETRY = 2
`ifdef MATCH_MANAGER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   kick_game,
    input  logic                   my_target_a,
    match_manager_if.master        bus,
    output logic [ROWS*COLS-1:0]   board_a,
    output logic [ROWS*COLS-1:0]   board_b,
    output logic [SCORE_W-1:0]     score_a,
    output logic [SCORE_W-1:0]     score_b,
    output logic [SCORE_W-1:0]     game_no,
    output logic                   match_active,
    output logic                   match_done,
    output logic                   abort
);

    localparam logic [SCORE_W-1:0] WIN_TARGET  = SCORE_W'((NUM_GAMES + 1) / 2);
    localparam logic [SCORE_W-1:0] GAMES_LIMIT = SCORE_W'(NUM_GAMES);
    localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRY);

    mm_state_e state, next_state;
    side_e     side_to_move;
    logic [3:0] retry;
    logic      win_a_q, win_b_q;

    logic start_print, start_turn, start_recv, start_judge;
    logic print_done, turn_done, recv_done, judge_done;
    logic recv_fin, recv_bad, recv_cancel;
    logic is_local;
    logic [3:0] retry_inc;
    logic retry_exhausted;
    logic a_won, b_won;
    logic [SCORE_W-1:0] score_a_inc, score_b_inc;
    logic match_over;

    assign is_local        = (side_to_move == (my_target_a ? SIDE_A : SIDE_B));
    assign retry_inc       = retry + 4'd1;
    assign retry_exhausted = (retry_inc > RETRY_LIMIT);
    // Both win flags set is scored as a draw
    assign a_won           = win_a_q & ~win_b_q;
    assign b_won           = win_b_q & ~win_a_q;
    assign score_a_inc     = score_a + SCORE_W'(a_won);
    assign score_b_inc     = score_b + SCORE_W'(b_won);
    assign match_over      = ((game_no + SCORE_W'(1)) == GAMES_LIMIT) ||
                             (score_a_inc == WIN_TARGET) || (score_b_inc == WIN_TARGET);

`ifdef MATCH_MANAGER_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        recv_pending;
    logic        recv_timeout;

    assign recv_timeout = recv_pending & ~recv_done & (to_cnt == 32'(TIMEOUT_CYC - 1));
    assign recv_fin     = recv_done | recv_timeout;
    assign recv_bad     = recv_timeout | bus.recv_error;
    assign recv_cancel  = recv_timeout;

    // Cycle counter for an outstanding recv; restarts with every recv_req
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt       <= 32'd0;
            recv_pending <= 1'b0;
        end else if (bus.recv_req) begin
            to_cnt       <= 32'd0;
            recv_pending <= 1'b1;
        end else if (recv_pending) begin
            if (recv_done || recv_timeout) begin
                recv_pending <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 32'd1;
            end
        end
    end
`else
    assign recv_fin    = recv_done;
    assign recv_bad    = bus.recv_error;
    assign recv_cancel = 1'b0;
`endif

    req_ready_tracker u_print (
        .clk(clk), .reset(reset), .start(start_print), .ready(bus.print_board_ready),
        .cancel(1'b0), .req(bus.print_board_wr), .done(print_done)
    );
    req_ready_tracker u_turn (
        .clk(clk), .reset(reset), .start(start_turn), .ready(bus.make_turn_ready),
        .cancel(1'b0), .req(bus.make_turn_req), .done(turn_done)
    );
    req_ready_tracker u_recv (
        .clk(clk), .reset(reset), .start(start_recv), .ready(bus.recv_ready),
        .cancel(recv_cancel), .req(bus.recv_req), .done(recv_done)
    );
    req_ready_tracker u_judge (
        .clk(clk), .reset(reset), .start(start_judge), .ready(bus.make_judge_ready),
        .cancel(1'b0), .req(bus.make_judge_req), .done(judge_done)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and sub-block start requests; a failed recv stays in MOVE
    // so the tracker reissues the request on the following cycle
    always_comb begin
        next_state  = state;
        start_print = 1'b0;
        start_turn  = 1'b0;
        start_recv  = 1'b0;
        start_judge = 1'b0;
        case (state)
            ST_IDLE: begin
                if (kick_game) next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                next_state = ST_PRINT;
            end
            ST_PRINT: begin
                start_print = 1'b1;
                if (print_done) next_state = ST_MOVE;
            end
            ST_MOVE: begin
                if (is_local) begin
                    start_turn = 1'b1;
                    if (turn_done) next_state = ST_JUDGE;
                end else begin
                    start_recv = 1'b1;
                    if (recv_fin) begin
                        if (!recv_bad) begin
                            next_state = ST_JUDGE;
                        end else if (retry_exhausted) begin
                            next_state = ST_MATCH_END;
                        end
                    end
                end
            end
            ST_JUDGE: begin
                start_judge = 1'b1;
                if (judge_done) next_state = bus.end_of_game ? ST_GAME_END : ST_PRINT;
            end
            ST_GAME_END: begin
                next_state = match_over ? ST_MATCH_END : ST_CLEAR;
            end
            ST_MATCH_END: begin
                if (!kick_game) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Match datapath: boards, scores, side to move, retry count and status.
    // Judge win flags are captured on completion and scored in GAME_END.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            board_a      <= '0;
            board_b      <= '0;
            score_a      <= '0;
            score_b      <= '0;
            game_no      <= '0;
            match_active <= 1'b0;
            match_done   <= 1'b0;
            abort        <= 1'b0;
            side_to_move <= SIDE_A;
            retry        <= 4'd0;
            win_a_q      <= 1'b0;
            win_b_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (kick_game) begin
                        score_a      <= '0;
                        score_b      <= '0;
                        game_no      <= '0;
                        match_active <= 1'b1;
                        match_done   <= 1'b0;
                        abort        <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    board_a      <= '0;
                    board_b      <= '0;
                    side_to_move <= game_no[0] ? SIDE_B : SIDE_A;
                    retry        <= 4'd0;
                end
                ST_MOVE: begin
                    if (is_local) begin
                        if (turn_done) begin
                            board_a <= bus.make_turn_board_a;
                            board_b <= bus.make_turn_board_b;
                        end
                    end else if (recv_fin) begin
                        if (!recv_bad) begin
                            board_a <= bus.recv_board_a;
                            board_b <= bus.recv_board_b;
                            retry   <= 4'd0;
                        end else begin
                            retry <= retry_inc;
                            if (retry_exhausted) abort <= 1'b1;
                        end
                    end
                end
                ST_JUDGE: begin
                    if (judge_done) begin
                        if (bus.end_of_game) begin
                            win_a_q <= bus.win_a;
                            win_b_q <= bus.win_b;
                        end else begin
                            side_to_move <= (side_to_move == SIDE_A) ? SIDE_B : SIDE_A;
                        end
                    end
                end
                ST_GAME_END: begin
                    score_a <= score_a_inc;
                    score_b <= score_b_inc;
                    game_no <= game_no + SCORE_W'(1);
                end
                default: begin
                end
            endcase
            if (next_state == ST_MATCH_END && state != ST_MATCH_END) begin
                match_active <= 1'b0;
                match_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_match_manager.sv
// Scoreboard bench for match_manager (default parameters).
// A reference model plays out each match from the game rules, queueing the
// expected request sequence (with the board visible at each request) and the
// sub-block responses. A monitor pops and compares on every request pulse.
module tb_match_manager;
    import game_pkg::*;

    localparam int CELLS      = 9;
    localparam int NUM_GAMES  = 3;
    localparam int MAX_RETRY  = 2;
    localparam int WIN_TARGET = 2;

    localparam int EV_PRINT = 0;
    localparam int EV_TURN  = 1;
    localparam int EV_RECV  = 2;
    localparam int EV_JUDGE = 3;

    typedef struct packed {
        logic [1:0]       kind;
        logic [CELLS-1:0] a;
        logic [CELLS-1:0] b;
    } ev_t;

    typedef struct packed {
        logic             f0;
        logic             f1;
        logic             f2;
        logic [CELLS-1:0] a;
        logic [CELLS-1:0] b;
    } resp_t;

    logic clk;
    logic reset;
    logic kick_game;
    logic my_target_a;
    logic [CELLS-1:0] board_a, board_b;
    logic [SCORE_W-1:0] score_a, score_b, game_no;
    logic match_active, match_done, abort;

    int checks;
    int passes;
    bit ready_random;

    ev_t   exp_q[$];
    resp_t turn_q[$];
    resp_t recv_q[$];
    resp_t judge_q[$];

    int exp_score_a, exp_score_b, exp_game_no;
    bit exp_abort;
    logic [CELLS-1:0] exp_board_a, exp_board_b;

    match_manager_if #(.CELLS(CELLS)) bus ();

    match_manager dut (
        .clk          (clk),
        .reset        (reset),
        .kick_game    (kick_game),
        .my_target_a  (my_target_a),
        .bus          (bus),
        .board_a      (board_a),
        .board_b      (board_b),
        .score_a      (score_a),
        .score_b      (score_b),
        .game_no      (game_no),
        .match_active (match_active),
        .match_done   (match_done),
        .abort        (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and keep the tallies
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic ev_t mk_ev(input int kind, input logic [CELLS-1:0] a, input logic [CELLS-1:0] b);
        ev_t e;
        e.kind = 2'(kind);
        e.a    = a;
        e.b    = b;
        return e;
    endfunction

    function automatic resp_t mk_resp(input bit f0, input bit f1, input bit f2,
                                      input logic [CELLS-1:0] a, input logic [CELLS-1:0] b);
        resp_t r;
        r.f0 = f0;
        r.f1 = f1;
        r.f2 = f2;
        r.a  = a;
        r.b  = b;
        return r;
    endfunction

    // Reference model: plays a whole match from the rules.
    // mode 0: three moves per game, A wins each game, no recv errors
    // mode 1: random game lengths, random results, occasional recv errors
    // mode 2: every recv fails (forces an abort)
    task automatic buildMatch(input int mode);
        logic [CELLS-1:0] ba, bb, na, nb;
        int sa, sb, gno, moves, errs, w;
        bit side, local_side, err, wa, wb, eog, over, fin;
        sa = 0; sb = 0; gno = 0; over = 0; wa = 0; wb = 0;
        ba = '0; bb = '0;
        exp_abort  = 0;
        local_side = my_target_a ? 1'b0 : 1'b1;
        for (int g = 0; g < NUM_GAMES && !over; g++) begin
            ba = '0; bb = '0;
            side  = (g % 2 == 1);
            moves = (mode == 0) ? 3 : int'($urandom_range(1, 6));
            for (int m = 0; m < moves && !over; m++) begin
                exp_q.push_back(mk_ev(EV_PRINT, ba, bb));
                if (side == local_side) begin
                    na = CELLS'($urandom);
                    nb = CELLS'($urandom);
                    exp_q.push_back(mk_ev(EV_TURN, ba, bb));
                    turn_q.push_back(mk_resp(0, 0, 0, na, nb));
                    ba = na; bb = nb;
                end else begin
                    errs = 0;
                    fin  = 0;
                    while (!fin) begin
                        exp_q.push_back(mk_ev(EV_RECV, ba, bb));
                        na  = CELLS'($urandom);
                        nb  = CELLS'($urandom);
                        err = (mode == 2) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
                        recv_q.push_back(mk_resp(err, 0, 0, na, nb));
                        if (!err) begin
                            ba = na; bb = nb; fin = 1;
                        end else begin
                            errs++;
                            if (errs > MAX_RETRY) begin
                                exp_abort = 1; over = 1; fin = 1;
                            end
                        end
                    end
                end
                if (!over) begin
                    eog = (m == moves - 1);
                    w   = (mode == 0) ? 1 : int'($urandom_range(0, 3));
                    wa  = (w & 1) != 0;
                    wb  = (w & 2) != 0;
                    exp_q.push_back(mk_ev(EV_JUDGE, ba, bb));
                    judge_q.push_back(mk_resp(eog, wa, wb, '0, '0));
                    side = ~side;
                end
            end
            if (!over) begin
                if (wa && !wb) sa++;
                if (wb && !wa) sb++;
                gno++;
                if (sa == WIN_TARGET || sb == WIN_TARGET || gno == NUM_GAMES) over = 1;
            end
        end
        exp_score_a = sa;
        exp_score_b = sb;
        exp_game_no = gno;
        exp_board_a = ba;
        exp_board_b = bb;
    endtask

    // Run one match: model it, kick it, wait for the end and check results
    task automatic applyStimulus(input int mode, input bit target, input bit rnd);
        int cyc;
        my_target_a  = target;
        ready_random = rnd;
        buildMatch(mode);
        @(negedge clk);
        kick_game = 1'b1;
        @(negedge clk);
        kick_game = 1'b0;
        checkOutput("match_active_after_kick", match_active, 1);
        cyc = 0;
        while (!match_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("match_done", match_done, 1);
        checkOutput("match_active_at_end", match_active, 0);
        checkOutput("score_a", score_a, exp_score_a);
        checkOutput("score_b", score_b, exp_score_b);
        checkOutput("game_no", game_no, exp_game_no);
        checkOutput("abort", abort, exp_abort);
        checkOutput("final_board_a", board_a, exp_board_a);
        checkOutput("final_board_b", board_b, exp_board_b);
        checkOutput("unissued_requests", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Ready generators: update just after the rising edge so the monitor's
    // falling-edge view of req matches what the DUT registers
    initial begin
        int hold;
        hold = 0;
        bus.print_board_ready = 1'b1;
        bus.make_turn_ready   = 1'b1;
        bus.recv_ready        = 1'b1;
        bus.make_judge_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_random) begin
                bus.print_board_ready = ($urandom_range(0, 3) != 0);
                bus.recv_ready        = ($urandom_range(0, 3) != 0);
                bus.make_judge_ready  = ($urandom_range(0, 3) != 0);
                if (hold > 0) begin
                    hold--;
                    bus.make_turn_ready = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    hold = 20;
                    bus.make_turn_ready = 1'b0;
                end else begin
                    bus.make_turn_ready = 1'b1;
                end
            end else begin
                bus.print_board_ready = 1'b1;
                bus.make_turn_ready   = 1'b1;
                bus.recv_ready        = 1'b1;
                bus.make_judge_ready  = 1'b1;
            end
        end
    end

    // Sub-block responders: present the scripted result when the request is seen
    initial begin
        resp_t r;
        bus.make_turn_board_a = '0;
        bus.make_turn_board_b = '0;
        bus.recv_board_a      = '0;
        bus.recv_board_b      = '0;
        bus.recv_error        = 1'b0;
        bus.end_of_game       = 1'b0;
        bus.win_a             = 1'b0;
        bus.win_b             = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.make_turn_req) begin
                r = (turn_q.size() > 0) ? turn_q.pop_front() : '0;
                bus.make_turn_board_a = r.a;
                bus.make_turn_board_b = r.b;
            end
            if (bus.recv_req) begin
                r = (recv_q.size() > 0) ? recv_q.pop_front() : '0;
                bus.recv_error   = r.f0;
                bus.recv_board_a = r.a;
                bus.recv_board_b = r.b;
            end
            if (bus.make_judge_req) begin
                r = (judge_q.size() > 0) ? judge_q.pop_front() : '0;
                bus.end_of_game = r.f0;
                bus.win_a       = r.f1;
                bus.win_b       = r.f2;
            end
        end
    end

    // Monitor: every request pulse is checked against the next expected event
    initial begin
        int  n_req;
        int  kind;
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_req = int'(bus.print_board_wr) + int'(bus.make_turn_req) +
                        int'(bus.recv_req) + int'(bus.make_judge_req);
                if (n_req > 1) begin
                    checks++;
                    $display("[TB] FAIL req_overlap: got %0d simultaneous requests, expected at most 1", n_req);
                end else if (n_req == 1) begin
                    kind = bus.print_board_wr ? EV_PRINT : bus.make_turn_req ? EV_TURN :
                           bus.recv_req ? EV_RECV : EV_JUDGE;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_req: got request kind %0d, expected none", kind);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("req_kind", kind, e.kind);
                        checkOutput("req_board_a", board_a, e.a);
                        checkOutput("req_board_b", board_b, e.b);
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        checks       = 0;
        passes       = 0;
        ready_random = 0;
        kick_game    = 1'b0;
        my_target_a  = 1'b1;
        reset        = 1'b1;
        #3 reset     = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("reset_outputs",
                    {board_a, board_b, score_a, score_b, game_no, match_active, match_done, abort,
                     bus.print_board_wr, bus.make_turn_req, bus.recv_req, bus.make_judge_req}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_release", {match_active, match_done, abort}, 0);

        $display("[TB] directed match: A wins two games");
        applyStimulus(0, 1'b1, 1'b0);

        $display("[TB] random matches");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] recv error exhaustion");
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 1'b1);

        $display("[TB] reset during judge");
        my_target_a  = 1'b1;
        ready_random = 1'b0;
        buildMatch(1);
        @(negedge clk);
        kick_game = 1'b1;
        @(negedge clk);
        kick_game = 1'b0;
        cyc = 0;
        while (!bus.make_judge_req && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("judge_req_seen", bus.make_judge_req, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {board_a, board_b, score_a, score_b, game_no, match_active, match_done, abort,
                     bus.print_board_wr, bus.make_turn_req, bus.recv_req, bus.make_judge_req}, 0);
        exp_q.delete();
        turn_q.delete();
        recv_q.delete();
        judge_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("quiet_after_reset", {match_active, match_done, abort}, 0);

        $display("[TB] recovery match");
        applyStimulus(1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
